// File: rtl/rm_report_arbiter.sv
// Report arbiter for one monitor stage: buffers one pending report per automaton,
// tagged with the symbol index it fired at, and drains them round-robin onto a valid/ready stream.
module rm_report_arbiter #(
   parameter int NUM_AUT = 9,
   parameter int REP_W   = 4,
   parameter int IDX_W   = 16,
   parameter int DROP_W  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     run,
   input  logic [NUM_AUT*REP_W-1:0] report_vec,
   output logic                     rpt_valid,
   input  logic                     rpt_ready,
   output logic [3:0]               rpt_aut_id,
   output logic [REP_W-1:0]         rpt_bits,
   output logic [IDX_W-1:0]         rpt_index,
   output logic                     overflow,
   output logic [DROP_W-1:0]        drop_count,
   output logic                     pending_any
);

   localparam int ID_W = 4;

   // Pending-report slots, one per automaton
   logic [NUM_AUT-1:0] occ_q, occ_d;
   logic [REP_W-1:0]   slot_bits_q [NUM_AUT];
   logic [REP_W-1:0]   slot_bits_d [NUM_AUT];
   logic [IDX_W-1:0]   slot_idx_q  [NUM_AUT];
   logic [IDX_W-1:0]   slot_idx_d  [NUM_AUT];

   // Output register and bookkeeping
   logic               valid_q, valid_d;
   logic [ID_W-1:0]    aut_q, aut_d;
   logic [REP_W-1:0]   bits_q, bits_d;
   logic [IDX_W-1:0]   index_q, index_d;
   logic [ID_W-1:0]    rr_q, rr_d;
   logic [IDX_W-1:0]   sym_q, sym_d;
   logic               ovf_q, ovf_d;
   logic [DROP_W-1:0]  drop_q, drop_d;

   logic               free;
   logic               grant_found;
   logic               grant;
   logic [ID_W-1:0]    grant_id;
   logic [ID_W:0]      cand_sum;
   logic [ID_W-1:0]    cand;
   logic [ID_W:0]      drop_n;
   logic [DROP_W:0]    drop_sum;

   // Round-robin search: first occupied slot starting just after the last grant.
   // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
   always_comb begin
      free        = !valid_q || rpt_ready;
      grant_found = 1'b0;
      grant_id    = '0;
      cand_sum    = '0;
      cand        = '0;
      for (int off = 1; off <= NUM_AUT; off++) begin
         cand_sum = {1'b0, rr_q} + (ID_W+1)'(off);
         if (cand_sum >= (ID_W+1)'(NUM_AUT)) begin
            cand_sum = cand_sum - (ID_W+1)'(NUM_AUT);
         end
         cand = cand_sum[ID_W-1:0];
         if (!grant_found && occ_q[cand]) begin
            grant_found = 1'b1;
            grant_id    = cand;
         end
      end
      grant = free && grant_found;
   end

   always_comb begin
      occ_d       = occ_q;
      slot_bits_d = slot_bits_q;
      slot_idx_d  = slot_idx_q;
      valid_d     = valid_q;
      aut_d       = aut_q;
      bits_d      = bits_q;
      index_d     = index_q;
      rr_d        = rr_q;
      sym_d       = sym_q;
      ovf_d       = ovf_q;
      drop_n      = '0;

      if (free) begin
         valid_d = grant_found;
         if (grant_found) begin
            aut_d           = grant_id;
            bits_d          = slot_bits_q[grant_id];
            index_d         = slot_idx_q[grant_id];
            occ_d[grant_id] = 1'b0;
            rr_d            = grant_id;
         end
      end

      // A slot being granted this edge counts as empty, so a same-edge refill is not a drop
      if (run) begin
         sym_d = sym_q + 1'b1;
         for (int a = 0; a < NUM_AUT; a++) begin
            if (report_vec[a*REP_W +: REP_W] != '0) begin
               if (!occ_q[a] || (grant && grant_id == ID_W'(a))) begin
                  occ_d[a]       = 1'b1;
                  slot_bits_d[a] = report_vec[a*REP_W +: REP_W];
                  slot_idx_d[a]  = sym_q;
               end else begin
                  drop_n = drop_n + 1'b1;
               end
            end
         end
      end

      drop_sum = {1'b0, drop_q} + (DROP_W+1)'(drop_n);
      if (drop_sum > {1'b0, {DROP_W{1'b1}}}) begin
         drop_d = '1;
      end else begin
         drop_d = drop_sum[DROP_W-1:0];
      end
      if (drop_n != '0) begin
         ovf_d = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q   <= '0;
         valid_q <= 1'b0;
         aut_q   <= '0;
         bits_q  <= '0;
         index_q <= '0;
         rr_q    <= ID_W'(NUM_AUT-1);
         sym_q   <= '0;
         ovf_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         occ_q   <= occ_d;
         valid_q <= valid_d;
         aut_q   <= aut_d;
         bits_q  <= bits_d;
         index_q <= index_d;
         rr_q    <= rr_d;
         sym_q   <= sym_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
      end
   end

   // NOTE: slot payloads are not reset; occ_q alone decides whether a slot's contents mean anything.
   always_ff @(posedge clk) begin
      slot_bits_q <= slot_bits_d;
      slot_idx_q  <= slot_idx_d;
   end

   assign rpt_valid   = valid_q;
   assign rpt_aut_id  = aut_q;
   assign rpt_bits    = bits_q;
   assign rpt_index   = index_q;
   assign overflow    = ovf_q;
   assign drop_count  = drop_q;
   assign pending_any = |occ_q;

endmodule

// File: tb/tb_rm_report_arbiter.sv
// Self-checking bench for rm_report_arbiter: scoreboard of expected reports plus
// directed sequences for drop, refill, run gating, index wrap and mid-run reset.
module tb_rm_report_arbiter;

   logic        clk;
   logic        reset;
   logic        run;
   logic [35:0] report_vec;
   logic        rpt_valid;
   logic        rpt_ready;
   logic [3:0]  rpt_aut_id;
   logic [3:0]  rpt_bits;
   logic [15:0] rpt_index;
   logic        overflow;
   logic [7:0]  drop_count;
   logic        pending_any;

   // Narrow-index instance for the wrap test
   logic        w_run;
   logic [35:0] w_vec;
   logic        w_rpt_valid;
   logic        w_rpt_ready;
   logic [3:0]  w_rpt_aut_id;
   logic [3:0]  w_rpt_bits;
   logic [3:0]  w_rpt_index;
   logic        w_overflow;
   logic [7:0]  w_drop_count;
   logic        w_pending_any;

   rm_report_arbiter dut (
      .clk(clk), .reset(reset), .run(run), .report_vec(report_vec),
      .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_aut_id(rpt_aut_id),
      .rpt_bits(rpt_bits), .rpt_index(rpt_index), .overflow(overflow),
      .drop_count(drop_count), .pending_any(pending_any)
   );

   rm_report_arbiter #(.IDX_W(4)) dut_w (
      .clk(clk), .reset(reset), .run(w_run), .report_vec(w_vec),
      .rpt_valid(w_rpt_valid), .rpt_ready(w_rpt_ready), .rpt_aut_id(w_rpt_aut_id),
      .rpt_bits(w_rpt_bits), .rpt_index(w_rpt_index), .overflow(w_overflow),
      .drop_count(w_drop_count), .pending_any(w_pending_any)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int tb_sym   = 0;
   logic [23:0] exp_q [$];

   typedef struct {
      logic [3:0] aut;
      logic [3:0] bits;
      logic       exp_load;
   } vec_t;
   vec_t tbl [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [35:0] hit(input logic [3:0] aut, input logic [3:0] bits);
      logic [35:0] v;
      v = '0;
      v[aut*4 +: 4] = bits;
      return v;
   endfunction

   task automatic push(input logic [3:0] aut, input logic [3:0] bits, input int idx);
      exp_q.push_back({aut, bits, 16'(idx)});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (reset) tb_sym = 0;
      else if (run) tb_sym++;
   endtask

   task automatic do_reset();
      reset = 1'b1; run = 1'b0; report_vec = '0; w_run = 1'b0; w_vec = '0;
      step();
      reset = 1'b0;
      tb_sym = 0;
      exp_q.delete();
   endtask

   // Scoreboard: every accepted transfer must match the oldest expected report
   always @(negedge clk) begin
      if (!reset && rpt_valid && rpt_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_report", 32'(exp_q.size()), 32'd1);
         end else begin
            check("sb_report", {8'h0, rpt_aut_id, rpt_bits, rpt_index}, {8'h0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{aut: 4'd0, bits: 4'hF, exp_load: 1'b1};
      tbl[1] = '{aut: 4'd8, bits: 4'h1, exp_load: 1'b1};
      tbl[2] = '{aut: 4'd5, bits: 4'h0, exp_load: 1'b0};
      tbl[3] = '{aut: 4'd7, bits: 4'hA, exp_load: 1'b1};
      tbl[4] = '{aut: 4'd3, bits: 4'h0, exp_load: 1'b0};
      tbl[5] = '{aut: 4'd2, bits: 4'h8, exp_load: 1'b1};

      reset = 1'b1; run = 1'b0; report_vec = '0; rpt_ready = 1'b1;
      w_run = 1'b0; w_vec = '0; w_rpt_ready = 1'b1;
      do_reset();
      check("rst_valid", rpt_valid, 0);
      check("rst_payload", {rpt_aut_id, rpt_bits, rpt_index}, 0);
      check("rst_overflow", overflow, 0);
      check("rst_drop_count", drop_count, 0);
      check("rst_pending", pending_any, 0);

      // Single hit: automaton 3, bits 0101, at symbol index 5
      run = 1'b1;
      repeat (5) step();
      report_vec = hit(4'd3, 4'b0101);
      push(4'd3, 4'b0101, tb_sym);
      step();
      report_vec = '0;
      check("single_not_yet_valid", rpt_valid, 0);
      check("single_pending", pending_any, 1);
      step();
      check("single_valid", rpt_valid, 1);
      check("single_payload", {rpt_aut_id, rpt_bits, rpt_index}, {4'd3, 4'd5, 16'd5});
      step();
      check("single_drained", rpt_valid, 0);

      // Table of single hits, including zero-bit vectors that must never load
      for (int i = 0; i < 6; i++) begin
         report_vec = hit(tbl[i].aut, tbl[i].bits);
         if (tbl[i].bits != 4'h0) push(tbl[i].aut, tbl[i].bits, tb_sym);
         step();
         report_vec = '0;
         check("tbl_pending", pending_any, tbl[i].exp_load);
         step();
         step();
      end
      check("tbl_drained", exp_q.size(), 0);

      // Round-robin: 0, 2, 8 together, then 0 and 2 again after rr sits at 8
      do_reset();
      run = 1'b1; rpt_ready = 1'b1;
      report_vec = hit(4'd0, 4'h1) | hit(4'd2, 4'h2) | hit(4'd8, 4'h3);
      push(4'd0, 4'h1, tb_sym); push(4'd2, 4'h2, tb_sym); push(4'd8, 4'h3, tb_sym);
      step();
      report_vec = '0;
      repeat (3) step();
      check("rr_last_grant", rpt_aut_id, 8);
      report_vec = hit(4'd0, 4'h4) | hit(4'd2, 4'h5);
      push(4'd0, 4'h4, tb_sym); push(4'd2, 4'h5, tb_sym);
      step();
      report_vec = '0;
      repeat (3) step();
      check("rr_drained", exp_q.size(), 0);

      // Backpressure and drops, then run gating, then drain in round-robin order
      do_reset();
      run = 1'b1; rpt_ready = 1'b0;
      repeat (10) step();
      report_vec = hit(4'd1, 4'h9);  step();
      report_vec = hit(4'd1, 4'hA);  step();
      report_vec = hit(4'd1, 4'hB);  step();
      check("bp_overflow", overflow, 1);
      check("bp_drop_one", drop_count, 1);
      check("bp_hold_payload", {rpt_valid, rpt_aut_id, rpt_bits, rpt_index}, {1'b1, 4'd1, 4'h9, 16'd10});
      report_vec = hit(4'd1, 4'hC) | hit(4'd5, 4'h3); step();
      report_vec = hit(4'd1, 4'hD) | hit(4'd5, 4'h4); step();
      check("bp_drop_multi", drop_count, 4);
      run = 1'b0;
      report_vec = hit(4'd1, 4'hF) | hit(4'd7, 4'hF);
      step(); step();
      check("gate_no_drop", drop_count, 4);
      check("gate_hold_payload", {rpt_valid, rpt_aut_id, rpt_bits, rpt_index}, {1'b1, 4'd1, 4'h9, 16'd10});
      report_vec = '0;
      push(4'd1, 4'h9, 10); push(4'd5, 4'h3, 13); push(4'd1, 4'hA, 11);
      rpt_ready = 1'b1;
      repeat (4) step();
      check("bp_valid_clear", rpt_valid, 0);
      check("bp_pending_clear", pending_any, 0);
      run = 1'b1;
      report_vec = hit(4'd2, 4'h1);
      push(4'd2, 4'h1, tb_sym);
      check("gate_sym_held", tb_sym, 15);
      step();
      report_vec = '0;
      step(); step();
      check("bp_drained", exp_q.size(), 0);

      // Same-edge grant and refill of automaton 4
      do_reset();
      run = 1'b1; rpt_ready = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         report_vec = hit(4'd4, 4'(k));
         push(4'd4, 4'(k), tb_sym);
         step();
      end
      report_vec = '0;
      repeat (3) step();
      check("refill_no_overflow", overflow, 0);
      check("refill_no_drop", drop_count, 0);
      check("refill_drained", exp_q.size(), 0);

      // Run gating and index wrap on the 4-bit index instance
      do_reset();
      w_vec = hit(4'd2, 4'h1);
      repeat (3) step();
      check("wrap_gate_no_capture", w_pending_any, 0);
      w_vec = '0; w_run = 1'b1;
      repeat (15) step();
      w_vec = hit(4'd2, 4'h1); step();
      w_vec = hit(4'd6, 4'h7); step();
      check("wrap_idx15", {w_rpt_valid, w_rpt_aut_id, w_rpt_index}, {1'b1, 4'd2, 4'd15});
      w_vec = '0; step();
      check("wrap_idx0", {w_rpt_valid, w_rpt_aut_id, w_rpt_bits, w_rpt_index}, {1'b1, 4'd6, 4'h7, 4'd0});
      w_run = 1'b0;

      // Mid-operation reset with five slots pending and the output register full
      do_reset();
      run = 1'b1; rpt_ready = 1'b0;
      report_vec = hit(4'd0, 4'h1) | hit(4'd1, 4'h1) | hit(4'd2, 4'h1) |
                   hit(4'd3, 4'h1) | hit(4'd4, 4'h1) | hit(4'd5, 4'h1);
      step();
      report_vec = '0; step();
      report_vec = hit(4'd1, 4'h2); step();
      report_vec = '0;
      check("mid_pre_valid", rpt_valid, 1);
      check("mid_pre_overflow", overflow, 1);
      reset = 1'b1; run = 1'b0;
      step();
      reset = 1'b0;
      check("mid_rst_valid", rpt_valid, 0);
      check("mid_rst_pending", pending_any, 0);
      check("mid_rst_overflow", overflow, 0);
      check("mid_rst_drop_count", drop_count, 0);
      run = 1'b1; rpt_ready = 1'b1;
      report_vec = hit(4'd5, 4'h2) | hit(4'd0, 4'h3);
      push(4'd0, 4'h3, tb_sym); push(4'd5, 4'h2, tb_sym);
      step();
      report_vec = '0;
      repeat (3) step();
      check("mid_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
